stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM that sequences counter_core as a two-button stopwatch.
//  Turns raw start/stop and lap/reset buttons into the count enable and clear strobes for counter_core.
//  Drives the display outputs with either the live count or a frozen lap snapshot.
//  Sits between the board buttons and counter_core; its display outputs feed the 7-seg driver.
// PARAMETERS
//  MIN_W       6   width of minute field
//  SEC_W       6   width of second field
//  MS_W        7   width of 10 ms field (0..99)
//  DEB_CYCLES  2   stable cycles needed to accept a button level (only with STOPWATCH_DEBOUNCE_EN); >=1
// PORTS
//  clk          in   1      system clock, 100 Hz (10 ms period); counter_core ticks once per enabled clk
//  rst          in   1      asynchronous, active-high reset
//  btn_ss       in   1      start/stop button, asynchronous, active-high
//  btn_lr       in   1      lap/reset button, asynchronous, active-high
//  min_i        in   MIN_W  live minutes from counter_core
//  sec_i        in   SEC_W  live seconds from counter_core
//  ms_10_i      in   MS_W   live 10 ms count from counter_core
//  cnt_en       out  1      count enable to counter_core
//  cnt_clr      out  1      one-cycle synchronous clear strobe to counter_core
//  min_o        out  MIN_W  displayed minutes
//  sec_o        out  SEC_W  displayed seconds
//  ms_10_o      out  MS_W   displayed 10 ms count
//  state_o      out  2      current state: 00 IDLE, 01 RUN, 10 LAP, 11 PAUSE
// BEHAVIOUR
//  Input conditioning
//  - Each button passes through a 2-flop synchronizer, then a registered previous-level flop.
//  - A press event is a single-cycle pulse: synced level = 1 and previous level = 0.
//  - Holding a button produces exactly one event; release produces none.
//  Latency
//  - A button rising before clk edge N updates the state on edge N+2.
//  - cnt_en, cnt_clr, state_o and the display mux decode combinationally from registered state/flags; no further delay.
//  State machine (events: SS from btn_ss, LR from btn_lr)
//  - IDLE  (cnt_en=0, live display): SS -> RUN; LR ignored.
//  - RUN   (cnt_en=1, live display): SS -> PAUSE; LR -> LAP and latch min_i/sec_i/ms_10_i into the snapshot on the same edge.
//  - LAP   (cnt_en=1, snapshot display): LR -> RUN (release the freeze); SS -> PAUSE (display returns to live).
//  - PAUSE (cnt_en=0, live display): SS -> RUN; LR -> IDLE and assert cnt_clr for exactly the first cycle in IDLE.
//  Simultaneous events
//  - If SS and LR occur in the same cycle, SS wins and LR is discarded.
//  Counting and clear
//  - The counter keeps running in LAP.
//  - Counter wrap (59:59.99 -> 00:00.00) is handled by counter_core; this block takes no action.
//  - cnt_clr is a registered flag, high for one cycle after entering IDLE from PAUSE and low otherwise.
//  Reset
//  - rst asserted at any time: state=IDLE, cnt_en=0, cnt_clr=0, snapshot=0, synchronizer and previous-level flops=0.
//  - Any press in flight is lost.
//  - The display shows the live inputs; counter_core is reset by the same rst.
// CONFIGURATION
//  STOPWATCH_DEBOUNCE_EN defined
//  - After synchronization, each button has a saturating counter of width clog2(DEB_CYCLES+1).
//  - The filtered level changes only after the synced level has differed from it for DEB_CYCLES consecutive cycles.
//  - Edge detection runs on the filtered level.
//  - Added latency is DEB_CYCLES cycles; glitches shorter than DEB_CYCLES cycles are rejected.
//  STOPWATCH_DEBOUNCE_EN undefined
//  - No filter; edge detection runs directly on the synced level.
//  - DEB_CYCLES is unused.
// TESTING
//  1. Reset, press btn_ss 1 cycle -> state_o=01 and cnt_en=1 from edge N+2; display tracks min_i/sec_i/ms_10_i.
//  2. In RUN with inputs 00:12.34, press btn_lr -> state_o=10 and display holds 00:12.34 while inputs advance to 00:15.00; cnt_en stays 1; press btn_lr again -> live display.
//  3. RUN -> btn_ss -> PAUSE (cnt_en=0) -> btn_lr -> state_o=00 and cnt_clr=1 for exactly 1 cycle, then 0; a second btn_lr in IDLE gives no pulse.
//  4. btn_ss and btn_lr rise in the same cycle while in RUN -> PAUSE, not LAP; snapshot is unchanged.
//  5. Hold btn_ss high for 50 cycles from IDLE -> exactly one transition, to RUN; release gives no change.
//  6. Assert rst mid-LAP -> all outputs at reset values immediately; with STOPWATCH_DEBOUNCE_EN and DEB_CYCLES=2, a 1-cycle btn_ss glitch causes no transition.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch controller: conditions the buttons, sequences counter_core, muxes live/lap display.
// Optional button debounce filter is enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
  parameter int MIN_W      = 6,
  parameter int SEC_W      = 6,
  parameter int MS_W       = 7,
  parameter int DEB_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_ss,
  input  logic             btn_lr,
  input  logic [MIN_W-1:0] min_i,
  input  logic [SEC_W-1:0] sec_i,
  input  logic [MS_W-1:0]  ms_10_i,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic [MS_W-1:0]  ms_10_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_LAP   = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  // Bit 0 carries the start/stop button, bit 1 the lap/reset button.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] prev_q;
  logic [1:0] lvl;
  logic       ss_evt;
  logic       lr_evt;

  state_t           state_q, state_d;
  logic             clr_q, clr_d;
  logic             snap_load;
  logic [MIN_W-1:0] snap_min_q;
  logic [SEC_W-1:0] snap_sec_q;
  logic [MS_W-1:0]  snap_ms_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {btn_lr, btn_ss};
      sync2_q <= sync1_q;
      prev_q  <= lvl;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       flt_q, flt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  // The filtered level follows the synced level only after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    flt_d = flt_q;
    for (int b = 0; b < 2; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != flt_q[b]) begin
        if (cnt_q[b] == CNT_LAST) begin
          flt_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q    <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      flt_q    <= flt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = sync2_q;
`endif

  assign ss_evt = lvl[0] & ~prev_q[0];
  assign lr_evt = lvl[1] & ~prev_q[1];

  // Start/stop is tested first in every state so it wins over a simultaneous lap/reset.
  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_evt) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_evt) begin
          state_d = S_PAUSE;
        end else if (lr_evt) begin
          state_d   = S_LAP;
          snap_load = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_evt) begin
          state_d = S_PAUSE;
        end else if (lr_evt) begin
          state_d = S_RUN;
        end
      end
      S_PAUSE: begin
        if (ss_evt) begin
          state_d = S_RUN;
        end else if (lr_evt) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_min_q <= '0;
      snap_sec_q <= '0;
      snap_ms_q  <= '0;
    end else if (snap_load) begin
      snap_min_q <= min_i;
      snap_sec_q <= sec_i;
      snap_ms_q  <= ms_10_i;
    end
  end

  assign cnt_en  = (state_q == S_RUN) || (state_q == S_LAP);
  assign cnt_clr = clr_q;
  assign state_o = state_q;
  assign min_o   = (state_q == S_LAP) ? snap_min_q : min_i;
  assign sec_o   = (state_q == S_LAP) ? snap_sec_q : sec_i;
  assign ms_10_o = (state_q == S_LAP) ? snap_ms_q  : ms_10_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: table of per-cycle vectors through a scoreboard queue, plus hold/glitch/reset sequences.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss, btn_lr;
  logic [5:0] min_i, sec_i;
  logic [6:0] ms_10_i;
  logic       cnt_en, cnt_clr;
  logic [5:0] min_o, sec_o;
  logic [6:0] ms_10_o;
  logic [1:0] state_o;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MIN_W(6), .SEC_W(6), .MS_W(7), .DEB_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .min_i(min_i), .sec_i(sec_i), .ms_10_i(ms_10_i),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .min_o(min_o), .sec_o(sec_o), .ms_10_o(ms_10_o), .state_o(state_o)
  );

  typedef struct {
    int ss, lr, mi, se, ms;
    int st, en, clr, dmi, dse, dms;
  } row_t;

  row_t tbl[$];
  row_t exp_q[$];
  int total = 0;
  int bad = 0;

  localparam int I = 0, R = 1, L = 2, P = 3;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input int ss, lr, mi, se, ms, st, en, clr, dmi, dse, dms);
    row_t r;
    r.ss = ss; r.lr = lr; r.mi = mi; r.se = se; r.ms = ms;
    r.st = st; r.en = en; r.clr = clr; r.dmi = dmi; r.dse = dse; r.dms = dms;
    tbl.push_back(r);
  endtask

  task automatic lv(input int ss, lr, mi, se, ms, st, en, clr);
    add(ss, lr, mi, se, ms, st, en, clr, mi, se, ms);
  endtask

  task automatic drive(input int ss, lr, mi, se, ms);
    btn_ss  = ss[0];
    btn_lr  = lr[0];
    min_i   = 6'(mi);
    sec_i   = 6'(se);
    ms_10_i = 7'(ms);
  endtask

  task automatic chk_outs(input string tag, input int st, en, clr, dmi, dse, dms);
    chk({tag, ".state"}, int'(state_o), st);
    chk({tag, ".cnt_en"}, int'(cnt_en), en);
    chk({tag, ".cnt_clr"}, int'(cnt_clr), clr);
    chk({tag, ".min"}, int'(min_o), dmi);
    chk({tag, ".sec"}, int'(sec_o), dse);
    chk({tag, ".ms"}, int'(ms_10_o), dms);
  endtask

  // Hold a button long enough to pass any filter, then release and let the event settle.
  task automatic press(input int ss, lr);
    drive(ss, lr, 0, 0, 0);
    repeat (EXTRA + 2) @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (EXTRA + 4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    row_t r;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk_outs("reset", I, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifndef STOPWATCH_DEBOUNCE_EN
    // start, lap freeze/release, pause, clear, simultaneous press, lap->pause
    lv(0,0, 0,0,0,   I,0,0);
    lv(1,0, 0,0,1,   I,0,0);
    lv(0,0, 0,0,2,   I,0,0);
    lv(0,0, 0,0,3,   R,1,0);
    lv(0,1, 0,12,30, R,1,0);
    lv(0,0, 0,12,32, R,1,0);
    add(0,0, 0,12,34, L,1,0, 0,12,34);
    add(0,0, 0,13,50, L,1,0, 0,12,34);
    add(0,1, 0,15,0,  L,1,0, 0,12,34);
    add(0,0, 0,15,1,  L,1,0, 0,12,34);
    lv(0,0, 0,15,2,  R,1,0);
    lv(1,0, 0,15,3,  R,1,0);
    lv(0,0, 0,15,4,  R,1,0);
    lv(0,0, 0,15,5,  P,0,0);
    lv(0,1, 0,15,5,  P,0,0);
    lv(0,0, 0,15,5,  P,0,0);
    lv(0,0, 0,15,5,  I,0,1);
    lv(0,0, 0,0,0,   I,0,0);
    lv(0,1, 0,0,0,   I,0,0);
    lv(0,0, 0,0,0,   I,0,0);
    lv(0,0, 0,0,0,   I,0,0);
    lv(0,0, 0,0,0,   I,0,0);
    lv(1,0, 0,0,0,   I,0,0);
    lv(0,0, 0,0,1,   I,0,0);
    lv(0,0, 0,0,2,   R,1,0);
    lv(1,1, 0,0,3,   R,1,0);
    lv(0,0, 0,0,4,   R,1,0);
    lv(0,0, 0,0,5,   P,0,0);
    lv(1,0, 0,0,5,   P,0,0);
    lv(0,0, 0,0,5,   P,0,0);
    lv(0,0, 0,0,6,   R,1,0);
    lv(0,1, 1,0,0,   R,1,0);
    lv(0,0, 1,0,1,   R,1,0);
    add(0,0, 1,0,2,  L,1,0, 1,0,2);
    add(1,0, 1,0,3,  L,1,0, 1,0,2);
    add(0,0, 1,0,4,  L,1,0, 1,0,2);
    lv(0,0, 1,0,5,   P,0,0);
    lv(0,0, 1,0,6,   P,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ss, tbl[i].lr, tbl[i].mi, tbl[i].se, tbl[i].ms);
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      r = exp_q.pop_front();
      chk_outs($sformatf("row%0d", i), r.st, r.en, r.clr, r.dmi, r.dse, r.dms);
    end
`endif

    // Long hold from IDLE: one transition only.
    do_reset();
    for (int k = 0; k < 50; k++) begin
      drive(1, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("hold%0d.state", k), int'(state_o), (k < 2 + EXTRA) ? I : R);
    end
    for (int k = 0; k < 6; k++) begin
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("release%0d.state", k), int'(state_o), R);
    end

    // Single-cycle pulse on btn_ss: a press without the filter, rejected with it.
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
    chk("glitch.state", int'(state_o), (EXTRA == 0) ? P : R);

    // Reset in the middle of a lap.
    do_reset();
    press(1, 0);
    drive(0, 0, 2, 3, 4);
    press(0, 1);
    drive(0, 0, 5, 6, 7);
    @(negedge clk);
    chk_outs("lap", L, 1, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("midrst", I, 0, 0, 5, 6, 7);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_outs("postrst", I, 0, 0, 5, 6, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
